ray_stepper: RTL and testbench



---
 rtl/ray_stepper_pkg.sv | 56 +++++
 rtl/ray_stepper_if.sv | 33 +++
 rtl/ray_stepper.sv | 117 +++++++++++
 tb/tb_ray_stepper.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_stepper_pkg.sv
// Shared fixed-point / vec3 types and arithmetic helpers for the vector datapath.
// Fixed format is signed Q8.8; all helpers wrap on overflow (no saturation).
package ray_stepper_pkg;

  localparam int FIX_W       = 16;
  localparam int FIX_FRAC    = 8;
  localparam int RAY_COUNT_W = 8;

  typedef logic signed [FIX_W-1:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec3_t;

  typedef struct packed {
    vec3_t                  origin;
    vec3_t                  dir;
    fixed_t                 step;
    logic [RAY_COUNT_W-1:0] count;
  } ray_cmd_t;

  // Full-precision product, arithmetic shift back to Q8.8, then wrap to FIX_W bits.
  function automatic fixed_t fmul(fixed_t a, fixed_t b);
    logic signed [2*FIX_W-1:0] ax;
    logic signed [2*FIX_W-1:0] bx;
    logic signed [2*FIX_W-1:0] p;
    ax = {{FIX_W{a[FIX_W-1]}}, a};
    bx = {{FIX_W{b[FIX_W-1]}}, b};
    p  = ax * bx;
    p  = p >>> FIX_FRAC;
    return fixed_t'(p);
  endfunction

  function automatic fixed_t fadd(fixed_t a, fixed_t b);
    return a + b;
  endfunction

  function automatic vec3_t vmul(vec3_t v, fixed_t s);
    vec3_t r;
    r.x = fmul(v.x, s);
    r.y = fmul(v.y, s);
    r.z = fmul(v.z, s);
    return r;
  endfunction

  function automatic vec3_t vadd(vec3_t a, vec3_t b);
    vec3_t r;
    r.x = fadd(a.x, b.x);
    r.y = fadd(a.y, b.y);
    r.z = fadd(a.z, b.z);
    return r;
  endfunction

endpackage

// File: rtl/ray_stepper_if.sv
// Command and point channels of the ray stepper, grouped with master/slave views.
// Both channels: a transfer happens on a rising edge where valid && ready; the
// sender keeps valid and its payload stable until that edge.
interface ray_stepper_if
  import ray_stepper_pkg::*;
#(
  parameter int COUNT_W = 8
) ();

  logic               cmd_valid_in;
  logic               cmd_ready_out;
  vec3_t              origin_in;
  vec3_t              dir_in;
  fixed_t             step_in;
  logic [COUNT_W-1:0] count_in;
  logic               abort_in;
  logic               pt_valid_out;
  logic               pt_ready_in;
  vec3_t              pt_out;
  logic [COUNT_W-1:0] pt_idx_out;
  logic               pt_last_out;

  modport slave (
    input  cmd_valid_in, origin_in, dir_in, step_in, count_in, abort_in, pt_ready_in,
    output cmd_ready_out, pt_valid_out, pt_out, pt_idx_out, pt_last_out
  );

  modport master (
    output cmd_valid_in, origin_in, dir_in, step_in, count_in, abort_in, pt_ready_in,
    input  cmd_ready_out, pt_valid_out, pt_out, pt_idx_out, pt_last_out
  );

endinterface

// File: rtl/ray_stepper.sv
// Iterative ray-point generator: emits origin + k*(dir*step) for k = 0..count-1,
// one point per cycle under valid/ready backpressure, with synchronous abort.
module ray_stepper
  import ray_stepper_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  ray_stepper_if.slave bus,
  output logic [1:0]   state_dbg_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_e             state;
  logic               cmd_ready_r;
  logic               pt_valid_r;
  logic               pt_last_r;
  vec3_t              origin_r;
  vec3_t              dir_r;
  fixed_t             step_r;
  vec3_t              delta_r;
  vec3_t              pt_r;
  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] idx_r;
  logic [COUNT_W-1:0] idx_next;
  logic               cmd_fire;
  logic               pt_fire;

  assign cmd_fire = bus.cmd_valid_in && cmd_ready_r;
  assign pt_fire  = pt_valid_r && bus.pt_ready_in;
  assign idx_next = idx_r + CNT_ONE;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      pt_valid_r  <= 1'b0;
      pt_last_r   <= 1'b0;
      origin_r    <= '0;
      dir_r       <= '0;
      step_r      <= '0;
      delta_r     <= '0;
      pt_r        <= '0;
      count_r     <= '0;
      idx_r       <= '0;
    end else if (bus.abort_in) begin
      // Abort wins over any same-cycle command accept or point handshake.
      state       <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      pt_valid_r  <= 1'b0;
      pt_last_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            origin_r <= bus.origin_in;
            dir_r    <= bus.dir_in;
            step_r   <= bus.step_in;
            count_r  <= bus.count_in;
            // A zero-length command is consumed without leaving IDLE.
            if (bus.count_in != '0) begin
              state       <= ST_LOAD;
              cmd_ready_r <= 1'b0;
            end
          end
        end

        ST_LOAD: begin
          delta_r    <= vmul(dir_r, step_r);
          pt_r       <= origin_r;
          idx_r      <= '0;
          pt_valid_r <= 1'b1;
          pt_last_r  <= (count_r == CNT_ONE);
          state      <= ST_EMIT;
        end

        ST_EMIT: begin
          if (pt_fire) begin
            if (pt_last_r) begin
              state       <= ST_IDLE;
              cmd_ready_r <= 1'b1;
              pt_valid_r  <= 1'b0;
              pt_last_r   <= 1'b0;
            end else begin
              pt_r      <= vadd(pt_r, delta_r);
              idx_r     <= idx_next;
              pt_last_r <= (idx_next == (count_r - CNT_ONE));
            end
          end
        end

        default: begin
          state       <= ST_IDLE;
          cmd_ready_r <= 1'b1;
          pt_valid_r  <= 1'b0;
          pt_last_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready_out = cmd_ready_r;
  assign bus.pt_valid_out  = pt_valid_r;
  assign bus.pt_last_out   = pt_last_r;
  assign bus.pt_out        = pt_r;
  assign bus.pt_idx_out    = idx_r;
  assign state_dbg_out     = state;

endmodule

// File: tb/tb_ray_stepper.sv
// Bench for ray_stepper: closed-form reference points go into a scoreboard queue
// at command issue; an independent monitor pops and compares on each point handshake.
module tb_ray_stepper;
  import ray_stepper_pkg::*;

  localparam int COUNT_W = 8;
  localparam int EW      = COUNT_W + 1 + 3 * FIX_W;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [1:0] state_dbg_out;

  ray_stepper_if #(.COUNT_W(COUNT_W)) bus ();

  ray_stepper #(.COUNT_W(COUNT_W)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .bus          (bus),
    .state_dbg_out(state_dbg_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            rdy_mode = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [EW-1:0] pack(vec3_t p, logic [COUNT_W-1:0] idx, logic last);
    return {idx, last, p};
  endfunction

  // Reference: p_k = origin + k * trunc_q8_8(dir * step), wrapped to 16 bits.
  function automatic fixed_t model_coord(fixed_t o, fixed_t d, fixed_t s, int k);
    int prod;
    int dl;
    int sum;
    prod = int'(d) * int'(s);
    dl   = prod >>> FIX_FRAC;
    sum  = int'(o) + k * dl;
    return fixed_t'(sum);
  endfunction

  task automatic push_expected(input vec3_t o, input vec3_t d, input fixed_t s, input int n);
    vec3_t p;
    for (int k = 0; k < n; k++) begin
      p.x = model_coord(o.x, d.x, s, k);
      p.y = model_coord(o.y, d.y, s, k);
      p.z = model_coord(o.z, d.z, s, k);
      exp_q.push_back(pack(p, COUNT_W'(k), k == n - 1));
    end
  endtask

  function automatic vec3_t rand_vec();
    vec3_t v;
    v.x = fixed_t'($urandom_range(0, 65535));
    v.y = fixed_t'($urandom_range(0, 65535));
    v.z = fixed_t'($urandom_range(0, 65535));
    return v;
  endfunction

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_cmd(input vec3_t o, input vec3_t d, input fixed_t s, input int n);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid_in = 1'b1;
    bus.origin_in    = o;
    bus.dir_in       = d;
    bus.step_in      = s;
    bus.count_in     = COUNT_W'(n);
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk_in);
      if (bus.cmd_ready_out) begin
        ok = 1'b1;
        push_expected(o, d, s, n);
      end
      @(posedge clk_in);
      #1;
    end
    bus.cmd_valid_in = 1'b0;
    check(ok, "cmd_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk_in);
      if (exp_q.size() == 0 && bus.cmd_ready_out && !bus.pt_valid_out) ok = 1'b1;
    end
    check(ok, "drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_idx(input int target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk_in);
      #1;
      if (bus.pt_valid_out && bus.pt_idx_out == COUNT_W'(target)) found = 1'b1;
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    int phase;
    phase = 0;
    bus.pt_ready_in = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      case (rdy_mode)
        0:       bus.pt_ready_in = 1'b1;
        1:       bus.pt_ready_in = 1'($urandom_range(0, 1));
        default: bus.pt_ready_in = (phase == 0 || phase == 3);
      endcase
      phase = (phase + 1) % 4;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin : monitor
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    logic [EW-1:0] prev_pk;
    bit            prev_stall;
    if (!rst_n_in) begin
      prev_stall = 1'b0;
    end else begin
      act = pack(bus.pt_out, bus.pt_idx_out, bus.pt_last_out);
      if (!bus.pt_valid_out)
        check(!bus.pt_last_out, "last_without_valid", 64'(bus.pt_last_out), 64'd0);
      else if (prev_stall)
        check(act == prev_pk, "hold_under_stall", 64'(act), 64'(prev_pk));
      if (bus.pt_valid_out && bus.pt_ready_in && !bus.abort_in) begin
        check(exp_q.size() > 0, "point_expected", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check(act == exp, "point", 64'(act), 64'(exp));
        end
      end
      prev_stall = bus.pt_valid_out && !bus.pt_ready_in && !bus.abort_in;
      prev_pk    = act;
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    vec3_t  o;
    vec3_t  d;
    fixed_t s;
    bit     found;
    int     n;

    rst_n_in         = 1'b0;
    bus.cmd_valid_in = 1'b0;
    bus.origin_in    = '0;
    bus.dir_in       = '0;
    bus.step_in      = '0;
    bus.count_in     = '0;
    bus.abort_in     = 1'b0;

    // Reset values
    repeat (3) @(negedge clk_in);
    check(bus.cmd_ready_out == 1'b1, "rst_cmd_ready", 64'(bus.cmd_ready_out), 64'd1);
    check(bus.pt_valid_out == 1'b0, "rst_pt_valid", 64'(bus.pt_valid_out), 64'd0);
    check(bus.pt_out == '0, "rst_pt_out", 64'(bus.pt_out), 64'd0);
    check(bus.pt_idx_out == '0, "rst_pt_idx", 64'(bus.pt_idx_out), 64'd0);
    check(bus.pt_last_out == 1'b0, "rst_pt_last", 64'(bus.pt_last_out), 64'd0);
    check(state_dbg_out == 2'd0, "rst_state", 64'(state_dbg_out), 64'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      check(!bus.pt_valid_out, "no_spurious_valid", 64'(bus.pt_valid_out), 64'd0);
    end
    @(posedge clk_in);
    #1;

    // Basic sequence with exact cycle timing
    o   = '0;
    d   = '0;
    d.x = 16'sh0100;
    s   = 16'sh0080;
    send_cmd(o, d, s, 4);
    @(negedge clk_in);
    check(!bus.cmd_ready_out && !bus.pt_valid_out, "load_cycle",
          64'({bus.cmd_ready_out, bus.pt_valid_out}), 64'd0);
    @(negedge clk_in);
    check(bus.pt_valid_out && bus.pt_idx_out == '0, "first_point_cycle2",
          64'({bus.pt_valid_out, bus.pt_idx_out}), 64'h100);
    repeat (3) @(negedge clk_in);
    check(bus.pt_valid_out && bus.pt_last_out && bus.pt_out.x == 16'sh0180, "last_point_cycle5",
          64'({bus.pt_last_out, bus.pt_out.x}), 64'h10180);
    @(negedge clk_in);
    check(bus.cmd_ready_out && !bus.pt_valid_out, "cmd_ready_cycle6",
          64'({bus.cmd_ready_out, bus.pt_valid_out}), 64'h2);
    wait_drain();

    // Backpressure 1,0,0,1,...
    rdy_mode = 2;
    send_cmd(o, d, s, 4);
    wait_drain();
    rdy_mode = 0;

    // Zero-count command
    send_cmd(rand_vec(), rand_vec(), fixed_t'($urandom_range(0, 65535)), 0);
    repeat (4) begin
      @(negedge clk_in);
      check(bus.cmd_ready_out && !bus.pt_valid_out, "zero_count_idle",
            64'({bus.cmd_ready_out, bus.pt_valid_out}), 64'h2);
    end
    @(posedge clk_in);
    #1;

    // Abort at idx 3 together with ready
    send_cmd(rand_vec(), rand_vec(), fixed_t'($urandom_range(0, 65535)), 10);
    wait_idx(3, found);
    check(found, "abort_reach_idx3", 64'(found), 64'd1);
    bus.abort_in = 1'b1;
    exp_q.delete();
    @(posedge clk_in);
    #1;
    bus.abort_in = 1'b0;
    check(!bus.pt_valid_out && bus.cmd_ready_out && state_dbg_out == 2'd0, "abort_to_idle",
          64'({bus.pt_valid_out, bus.cmd_ready_out, state_dbg_out}), 64'h4);
    send_cmd(rand_vec(), rand_vec(), fixed_t'($urandom_range(0, 65535)), 3);
    wait_drain();

    // Abort together with a command accept in IDLE: command is dropped
    bus.cmd_valid_in = 1'b1;
    bus.origin_in    = rand_vec();
    bus.count_in     = COUNT_W'(5);
    bus.abort_in     = 1'b1;
    @(negedge clk_in);
    check(bus.cmd_ready_out, "abort_idle_ready", 64'(bus.cmd_ready_out), 64'd1);
    @(posedge clk_in);
    #1;
    bus.cmd_valid_in = 1'b0;
    bus.abort_in     = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      check(!bus.pt_valid_out && state_dbg_out == 2'd0, "abort_drops_accept",
            64'({bus.pt_valid_out, state_dbg_out}), 64'd0);
    end
    @(posedge clk_in);
    #1;

    // Asynchronous reset mid-EMIT
    send_cmd(rand_vec(), rand_vec(), fixed_t'($urandom_range(0, 65535)), 8);
    wait_idx(2, found);
    check(found, "areset_reach_idx2", 64'(found), 64'd1);
    #2;
    rst_n_in = 1'b0;
    exp_q.delete();
    #1;
    check(!bus.pt_valid_out, "areset_valid", 64'(bus.pt_valid_out), 64'd0);
    check(bus.cmd_ready_out, "areset_cmd_ready", 64'(bus.cmd_ready_out), 64'd1);
    check(bus.pt_out == '0 && bus.pt_idx_out == '0 && !bus.pt_last_out, "areset_outputs",
          64'(pack(bus.pt_out, bus.pt_idx_out, bus.pt_last_out)), 64'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Randomized commands under random backpressure
    rdy_mode = 1;
    for (int c = 0; c < 20; c++) begin
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      send_cmd(rand_vec(), rand_vec(), fixed_t'($urandom_range(0, 65535)), n);
    end
    wait_drain();

    // Maximum-length command
    rdy_mode = 0;
    send_cmd(rand_vec(), rand_vec(), fixed_t'($urandom_range(0, 65535)), 255);
    wait_drain();

    check(exp_q.size() == 0, "queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
